// File: rtl/vga_timing_scanout_if.sv
`default_nettype none
// =============================================================================
// Module  : vga_timing_scanout_if
// Brief   : Line-buffer read port between the scanout (master) and line buffer.
// Revision: 1.0
// =============================================================================
interface vga_timing_scanout_if #(
  parameter int PIXEL_W = 24
);
  logic               lb_read_o;
  logic [PIXEL_W-1:0] lb_pixel_i;
  logic               lb_empty_i;

  modport master (output lb_read_o, input lb_pixel_i, input lb_empty_i);
  modport slave  (input lb_read_o, output lb_pixel_i, output lb_empty_i);
endinterface
`default_nettype wire

// File: rtl/vga_timing_scanout.sv
`default_nettype none
// =============================================================================
// Module  : vga_timing_scanout
// Brief   : 640x480/800x600 @60 raster timing with a 2-stage line-buffer scanout.
// Revision: 1.0
// =============================================================================
module vga_timing_scanout #(
  parameter int PIXEL_W  = 24,
  parameter int PIPE_LAT = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_video_i,
  input  logic                 resolution_i,
  vga_timing_scanout_if.master lb,
  output logic [PIXEL_W-1:0]   rgb_o,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic                 video_on_o,
  output logic                 line_start_o,
  output logic                 frame_start_o,
  output logic                 underflow_o
);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } region_t;

  if (PIPE_LAT != 2) begin : g_pipe_lat_chk
    $error("vga_timing_scanout: PIPE_LAT is fixed at 2");
  end

  region_t      r_h_state;
  region_t      r_v_state;
  logic [10:0]  r_h_cnt;
  logic [9:0]   r_v_cnt;
  logic         r_res;
  logic         r_vis1;
  logic         r_uf1;
  logic         r_hs1;
  logic         r_vs1;

  logic [10:0]  w_h_end;
  logic [9:0]   w_v_end;
  logic         w_run;
  logic         w_read;
  logic         w_res_chg;
  logic         w_h_step;
  logic         w_v_step;
  logic         w_h_wrap;
  logic         w_v_wrap;
  logic         w_hs_lvl;
  logic         w_vs_lvl;
  logic         w_idle_lvl;

  // First count past the end of the current region; BACK ends at the total.
  always_comb begin
    w_h_end = r_res ? 11'd1056 : 11'd800;
    w_v_end = r_res ? 10'd628  : 10'd525;
    case (r_h_state)
      ST_ACTIVE: w_h_end = r_res ? 11'd800 : 11'd640;
      ST_FRONT:  w_h_end = r_res ? 11'd840 : 11'd656;
      ST_SYNC:   w_h_end = r_res ? 11'd968 : 11'd752;
      default:   ;
    endcase
    case (r_v_state)
      ST_ACTIVE: w_v_end = r_res ? 10'd600 : 10'd480;
      ST_FRONT:  w_v_end = r_res ? 10'd601 : 10'd490;
      ST_SYNC:   w_v_end = r_res ? 10'd605 : 10'd492;
      default:   ;
    endcase
  end

  assign w_run      = rst_n_i & enable_video_i;
  assign w_res_chg  = w_run & (resolution_i != r_res);
  assign w_h_step   = (r_h_cnt + 11'd1) == w_h_end;
  assign w_v_step   = (r_v_cnt + 10'd1) == w_v_end;
  assign w_h_wrap   = w_h_step & (r_h_state == ST_BACK);
  assign w_v_wrap   = w_v_step & (r_v_state == ST_BACK);
  assign w_read     = w_run & (r_h_state == ST_ACTIVE) & (r_v_state == ST_ACTIVE);

  // 800x600 syncs are active-high, 640x480 active-low.
  assign w_hs_lvl   = (r_h_state == ST_SYNC) ? r_res : ~r_res;
  assign w_vs_lvl   = (r_v_state == ST_SYNC) ? r_res : ~r_res;
  assign w_idle_lvl = ~resolution_i;

  assign lb.lb_read_o  = w_read;
  assign line_start_o  = w_run & (r_h_cnt == 11'd0);
  assign frame_start_o = w_run & (r_h_cnt == 11'd0) & (r_v_cnt == 10'd0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_h_state   <= ST_ACTIVE;
      r_v_state   <= ST_ACTIVE;
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_res       <= 1'b0;
      r_vis1      <= 1'b0;
      r_uf1       <= 1'b0;
      r_hs1       <= 1'b1;
      r_vs1       <= 1'b1;
      rgb_o       <= '0;
      video_on_o  <= 1'b0;
      hsync_o     <= 1'b1;
      vsync_o     <= 1'b1;
      underflow_o <= 1'b0;
    end else begin
      if (!enable_video_i) begin
        underflow_o <= 1'b0;
      end else if (w_read && lb.lb_empty_i) begin
        underflow_o <= 1'b1;
      end

      // Disable or a mode change restarts the raster and blanks the pipeline.
      if (!enable_video_i || w_res_chg) begin
        r_h_state  <= ST_ACTIVE;
        r_v_state  <= ST_ACTIVE;
        r_h_cnt    <= '0;
        r_v_cnt    <= '0;
        r_res      <= resolution_i;
        r_vis1     <= 1'b0;
        r_uf1      <= 1'b0;
        r_hs1      <= w_idle_lvl;
        r_vs1      <= w_idle_lvl;
        rgb_o      <= '0;
        video_on_o <= 1'b0;
        hsync_o    <= w_idle_lvl;
        vsync_o    <= w_idle_lvl;
      end else begin
        if (w_h_step) begin
          r_h_state <= region_t'(r_h_state + 2'd1);
        end
        if (w_h_wrap) begin
          r_h_cnt <= '0;
          r_v_cnt <= w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
          if (w_v_step) begin
            r_v_state <= region_t'(r_v_state + 2'd1);
          end
        end else begin
          r_h_cnt <= r_h_cnt + 11'd1;
        end

        r_vis1     <= w_read;
        r_uf1      <= w_read & lb.lb_empty_i;
        r_hs1      <= w_hs_lvl;
        r_vs1      <= w_vs_lvl;

        rgb_o      <= (r_vis1 && !r_uf1) ? lb.lb_pixel_i : '0;
        video_on_o <= r_vis1;
        hsync_o    <= r_hs1;
        vsync_o    <= r_vs1;
      end
    end
  end

endmodule
`default_nettype wire
